// File: rtl/sel_code_gen_pkg.sv
// Shared types and constants for the select-code generator.
// The index width, the reset code and the debounce FSM encodings all live here.
package sel_code_gen_pkg;

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_RST = 3'b000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } deb_state_t;

  // Wrapping +1 / -1 step of the select index.
  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] idx,
                                                input logic             up);
    return up ? idx + IDX_W'(1) : idx - IDX_W'(1);
  endfunction

endpackage

// File: rtl/sel_code_gen_if.sv
// Bundle between the button/auto-scan source and the select-code generator.
// Signalling: key_* and auto_en are levels sampled on every clock; sel* and
// step_pulse are registered and valid every cycle; there is no backpressure.
interface sel_code_gen_if;

  logic key_up;
  logic key_dn;
  logic auto_en;
  logic sel1;
  logic sel2;
  logic sel3;
  logic step_pulse;
  sel_code_gen_pkg::deb_state_t up_state;
  sel_code_gen_pkg::deb_state_t dn_state;

  modport master (
    output key_up, key_dn, auto_en,
    input  sel1, sel2, sel3, step_pulse, up_state, dn_state
  );

  modport slave (
    input  key_up, key_dn, auto_en,
    output sel1, sel2, sel3, step_pulse, up_state, dn_state
  );

endinterface

// File: rtl/sel_code_gen_key_filter.sv
// Two-flop synchroniser plus debounce FSM for one active-low push-button.
// key_flag pulses for one cycle per stable press; holding gives no repeat.
module key_filter
  import sel_code_gen_pkg::*;
#(
  parameter logic [19:0] DEB_CNT = 20'd999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       key_flag,
  output deb_state_t state_dbg
);

  logic [1:0]  sync_q, sync_d;
  logic [1:0]  vld_q, vld_d;
  logic        armed_q, armed_d;
  deb_state_t  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        key_s;

  assign key_s     = sync_q[1];
  assign state_dbg = state_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q  <= 2'b11;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A key already held across reset must be seen released before it can
  // register again; vld_q marks when the synchroniser holds a real sample.
  always_comb begin
    sync_d   = {sync_q[0], key_in};
    vld_d    = {vld_q[0], 1'b1};
    armed_d  = armed_q | (vld_q[1] & key_s);
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_flag = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s && armed_q) begin
          state_d = PRESS_FILT;
          cnt_d   = '0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_CNT) begin
          state_d  = DOWN;
          key_flag = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      DOWN: begin
        if (key_s) begin
          state_d = REL_FILT;
          cnt_d   = '0;
        end
      end
      REL_FILT: begin
        if (!key_s) begin
          state_d = DOWN;
        end else if (cnt_q == DEB_CNT) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/sel_code_gen.sv
// Select-code generator: two debounced step buttons plus an optional auto-scan
// drive a wrapping 3-bit index that is presented registered on sel1..sel3.
module sel_code_gen
  import sel_code_gen_pkg::*;
#(
  parameter logic [19:0] DEB_CNT  = 20'd999_999,
  parameter logic [24:0] AUTO_CNT = 25'd24_999_999
) (
  input logic           sys_clk,
  input logic           sys_rst,
  sel_code_gen_if.slave bus
);

  logic             up_flag;
  logic             dn_flag;
  deb_state_t       up_state;
  deb_state_t       dn_state;
  logic [24:0]      auto_cnt_q, auto_cnt_d;
  logic             auto_tick;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             step_q, step_d;

  key_filter #(.DEB_CNT(DEB_CNT)) u_up (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_in    (bus.key_up),
    .key_flag  (up_flag),
    .state_dbg (up_state)
  );

  key_filter #(.DEB_CNT(DEB_CNT)) u_dn (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_in    (bus.key_dn),
    .key_flag  (dn_flag),
    .state_dbg (dn_state)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      auto_cnt_q <= '0;
      idx_q      <= IDX_RST;
      step_q     <= 1'b0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
      idx_q      <= idx_d;
      step_q     <= step_d;
    end
  end

  // A key press restarts the auto period, and a tick that lands together with
  // any key press is dropped so the key action alone decides the step.
  always_comb begin
    auto_tick = bus.auto_en && (auto_cnt_q == AUTO_CNT);
    if (!bus.auto_en || up_flag || dn_flag || auto_tick) begin
      auto_cnt_d = '0;
    end else begin
      auto_cnt_d = auto_cnt_q + 25'd1;
    end

    idx_d  = idx_q;
    step_d = 1'b0;
    if (up_flag && !dn_flag) begin
      idx_d  = idx_step(idx_q, 1'b1);
      step_d = 1'b1;
    end else if (dn_flag && !up_flag) begin
      idx_d  = idx_step(idx_q, 1'b0);
      step_d = 1'b1;
    end else if (!up_flag && !dn_flag && auto_tick) begin
      idx_d  = idx_step(idx_q, 1'b1);
      step_d = 1'b1;
    end
  end

  assign bus.sel1       = idx_q[2];
  assign bus.sel2       = idx_q[1];
  assign bus.sel3       = idx_q[0];
  assign bus.step_pulse = step_q;
  assign bus.up_state   = up_state;
  assign bus.dn_state   = dn_state;

endmodule

// File: doc/sel_code_gen.md
Name: sel_code_gen

Overview:
- Upstream stage of the 3-to-8 decoder. Produces the 3-bit select code `{sel1, sel2, sel3}` that drives the decoder inputs `{in1, in2, in3}`.
- Debounces two active-low push-buttons (step up, step down) and keeps a wrapping 3-bit index.
- An optional auto-scan mode advances the index on a fixed period, so the decoder output walks one-hot across the LEDs.
- Outputs are always registered and always one of the 8 defined codes, so the decoder never falls into its hold (`out = out`) path.

Parameters:
- DEB_CNT, 20'd999_999, debounce window in clock cycles minus one (20 ms at 50 MHz).
- AUTO_CNT, 25'd24_999_999, auto-scan step period in clock cycles minus one (0.5 s at 50 MHz).

Ports:
- sys_clk, input, 1, system clock; all logic on the rising edge.
- sys_rst, input, 1, asynchronous active-high reset.
- key_up, input, 1, raw asynchronous button, active-low; a press steps the index +1.
- key_dn, input, 1, raw asynchronous button, active-low; a press steps the index -1.
- auto_en, input, 1, level, synchronous to sys_clk; 1 = auto-scan enabled.
- sel1, output, 1, select code MSB; connects to decoder `in1`.
- sel2, output, 1, select code bit 1; connects to decoder `in2`.
- sel3, output, 1, select code LSB; connects to decoder `in3`.
- step_pulse, output, 1, one-cycle pulse in the cycle after the index changes.

Behaviour:
- Reset:
  - Asynchronous assert and synchronous release: sys_rst clears every flop immediately.
  - Reset values: idx = 3'd0, `{sel1, sel2, sel3}` = 3'b000, step_pulse = 0.
  - Both filters reset to IDLE, sync flops to 1 (released), auto counter to 0.
- Synchroniser: each key passes through 2 flops before its filter; their reset value is 1.
- Debounce FSM (one instance per key):
  - IDLE: key sync = 0 → PRESS_FILT and clear cnt.
  - PRESS_FILT: if key sync = 1 → IDLE. Else if cnt == DEB_CNT → DOWN and assert press (1 cycle). Else cnt + 1.
  - DOWN: key sync = 1 → REL_FILT and clear cnt.
  - REL_FILT: if key sync = 0 → DOWN. Else if cnt == DEB_CNT → IDLE. Else cnt + 1.
  - A bounce in any filter state restarts the window.
  - Exactly one press pulse per stable press; holding a key gives no auto-repeat.
- Auto counter:
  - Counts only while auto_en = 1.
  - At AUTO_CNT it wraps to 0 and asserts auto_tick for 1 cycle.
  - When auto_en = 0 it is held at 0.
  - Any key press pulse clears it to 0, so the next auto step is a full period later.
- Index update, per cycle:
  - up only → idx + 1 (7 wraps to 0).
  - dn only → idx - 1 (0 wraps to 7).
  - up and dn in the same cycle → no change, no step_pulse.
  - auto_tick with no key press → idx + 1.
  - auto_tick coinciding with a key press → the key action wins; the tick is discarded.
- Outputs:
  - `{sel1, sel2, sel3}` = idx, which is a register; sel1 is the MSB.
  - Latency: key press pulse → new idx on the next edge. step_pulse is high in the same cycle the new idx is visible.
  - Press-to-output latency = 2 (sync) + DEB_CNT + 1 (filter) + 1 (index register) cycles.
- auto_en deasserted mid-period: counter is zeroed and no pending tick is kept.
- Reset mid-debounce or mid-press: the filter returns to IDLE. A key still held at release must go high and low again to register.

Decomposition:
- Shared package: idx width (3), the reset code 3'b000, and the debounce FSM state encodings IDLE = 2'd0, PRESS_FILT = 2'd1, DOWN = 2'd2, REL_FILT = 2'd3.
- One sub-module, key_filter: synchroniser plus debounce FSM, parameter DEB_CNT, ports sys_clk / sys_rst / key_in / key_flag. It is instantiated twice.
- The top level holds the auto counter, the index register and the output drive.

Test Plan (sim parameters DEB_CNT = 4, AUTO_CNT = 9):
- Reset asserted mid-cycle, no clock → sel = 000 immediately, step_pulse = 0. Decoder then shows 8'b0000_0001.
- key_up held low 20 cycles with 3 bounces in the first 6 cycles → exactly one step_pulse, sel goes 000 → 001. Holding longer gives no further change.
- Seven clean key_dn presses from sel = 001 → sequence 000, 111, 110, 101, 100, 011, 010 (wrap 0 → 7 checked).
- key_up and key_dn forced so their debounced press pulses land in the same cycle → sel unchanged, step_pulse = 0.
- auto_en = 1 from sel = 110 → after 10 cycles 111, after 10 more 000. A key_up press mid-period restarts the 10-cycle interval.
- sys_rst pulsed while key_up is held inside DOWN → sel = 000. Key still held after release gives no step; release then press gives 000 → 001.
